// File: rtl/jtag_debug_scan_master.sv
// Host-side virtual-JTAG scan initiator: one IR update and an optional LSB-first
// DR scan per command, driving the strobe interface of a Nios debug module.
module jtag_debug_scan_master #(
  parameter int DR_WIDTH = 38,
  parameter int IR_WIDTH = 2,
  parameter int TCK_HALF = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic                cmd_ir_only,
  input  logic [DR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_data,
  output logic                busy,
  output logic                tck,
  output logic                tdi,
  input  logic                tdo,
  output logic [IR_WIDTH-1:0] ir_in,
  output logic                vs_uir,
  output logic                vs_cdr,
  output logic                vs_sdr,
  output logic                vs_udr,
  output logic                jtag_state_rti
);

  localparam int DIV_W = $clog2(2 * TCK_HALF);
  localparam int BIT_W = $clog2(DR_WIDTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * TCK_HALF - 1);
  localparam logic [DIV_W-1:0] DIV_HIGH = DIV_W'(TCK_HALF);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DR_WIDTH - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_UIR  = 3'd1;
  localparam logic [2:0] S_CDR  = 3'd2;
  localparam logic [2:0] S_SDR  = 3'd3;
  localparam logic [2:0] S_UDR  = 3'd4;
  localparam logic [2:0] S_RTI  = 3'd5;
  localparam logic [2:0] S_RESP = 3'd6;

  logic [2:0]          state_reg, state_next;
  logic [DIV_W-1:0]    div_reg, div_next;
  logic [BIT_W-1:0]    bit_reg, bit_next;
  logic                ir_only_reg, ir_only_next;
  logic [DR_WIDTH-1:0] shift_reg, shift_next;
  logic [DR_WIDTH-1:0] capture_reg, capture_next;
  logic                accept;
  logic                period_end;
  logic                in_scan_next;
  logic                tdi_next;

  assign accept     = (state_reg == S_IDLE) && cmd_valid && cmd_ready;
  assign period_end = (div_reg == DIV_LAST);

  always_comb begin
    state_next   = state_reg;
    div_next     = div_reg;
    bit_next     = bit_reg;
    ir_only_next = ir_only_reg;
    shift_next   = shift_reg;
    capture_next = capture_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          state_next   = S_UIR;
          div_next     = '0;
          bit_next     = '0;
          ir_only_next = cmd_ir_only;
          shift_next   = cmd_data;
          capture_next = '0;
        end
      end
      S_RESP: begin
        if (rsp_valid && rsp_ready) state_next = S_IDLE;
      end
      default: begin
        div_next = period_end ? '0 : div_reg + DIV_W'(1);
        // Sample tdo in the first high-tck clk, well after tdi has settled.
        if (state_reg == S_SDR && div_reg == DIV_HIGH) begin
          capture_next = {tdo, capture_reg[DR_WIDTH-1:1]};
          shift_next   = shift_reg >> 1;
        end
        if (period_end) begin
          case (state_reg)
            S_UIR: state_next = ir_only_reg ? S_RTI : S_CDR;
            S_CDR: state_next = S_SDR;
            S_SDR: begin
              if (bit_reg == BIT_LAST) state_next = S_UDR;
              else bit_next = bit_reg + BIT_W'(1);
            end
            S_UDR: state_next = S_RTI;
            S_RTI: state_next = S_RESP;
            default: state_next = S_IDLE;
          endcase
        end
      end
    endcase
  end

  assign in_scan_next = (state_next != S_IDLE) && (state_next != S_RESP);
  // tdi is reloaded only at the start of each SDR period so it stays flat across it.
  always_comb begin
    tdi_next = 1'b0;
    if (state_next == S_SDR) tdi_next = (div_next == '0) ? shift_next[0] : tdi;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg      <= S_IDLE;
      div_reg        <= '0;
      bit_reg        <= '0;
      ir_only_reg    <= 1'b0;
      shift_reg      <= '0;
      capture_reg    <= '0;
      cmd_ready      <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_data       <= '0;
      busy           <= 1'b0;
      tck            <= 1'b0;
      tdi            <= 1'b0;
      ir_in          <= '0;
      vs_uir         <= 1'b0;
      vs_cdr         <= 1'b0;
      vs_sdr         <= 1'b0;
      vs_udr         <= 1'b0;
      jtag_state_rti <= 1'b0;
    end else begin
      state_reg      <= state_next;
      div_reg        <= div_next;
      bit_reg        <= bit_next;
      ir_only_reg    <= ir_only_next;
      shift_reg      <= shift_next;
      capture_reg    <= capture_next;
      cmd_ready      <= (state_next == S_IDLE);
      busy           <= (state_next != S_IDLE);
      rsp_valid      <= (state_next == S_RESP);
      rsp_data       <= (state_next == S_RESP && !ir_only_next) ? capture_next : '0;
      tck            <= in_scan_next && (div_next >= DIV_HIGH);
      tdi            <= tdi_next;
      if (accept) ir_in <= cmd_ir;
      vs_uir         <= (state_next == S_UIR);
      vs_cdr         <= (state_next == S_CDR);
      vs_sdr         <= (state_next == S_SDR);
      vs_udr         <= (state_next == S_UDR);
      jtag_state_rti <= (state_next == S_RTI) || (state_next == S_IDLE);
    end
  end

endmodule

// File: tb/tb_jtag_debug_scan_master.sv
// Scoreboard bench for jtag_debug_scan_master: default-size instance plus a
// TCK_HALF=1 / DR_WIDTH=4 instance, both checked against bench-computed values.
module tb_jtag_debug_scan_master;

  localparam int DR_W   = 38;
  localparam int IR_W   = 2;
  localparam int TH     = 2;
  localparam int LAT_DR = (DR_W + 4) * 2 * TH + 1;
  localparam int LAT_IR = 2 * 2 * TH + 1;
  localparam int S_DR   = 4;
  localparam int S_LAT  = (S_DR + 4) * 2 * 1 + 1;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic            cmd_valid, cmd_ready, cmd_ir_only, rsp_valid, rsp_ready, busy;
  logic [IR_W-1:0] cmd_ir, ir_in;
  logic [DR_W-1:0] cmd_data, rsp_data;
  logic            tck, tdi, tdo, vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti;
  logic            tdo_loop, tdo_fixed;
  assign tdo = tdo_loop ? tdi : tdo_fixed;

  logic            s_cmd_valid, s_cmd_ready, s_cmd_ir_only, s_rsp_valid, s_rsp_ready, s_busy;
  logic [IR_W-1:0] s_cmd_ir, s_ir_in;
  logic [S_DR-1:0] s_cmd_data, s_rsp_data;
  logic            s_tck, s_tdi, s_vs_uir, s_vs_cdr, s_vs_sdr, s_vs_udr, s_rti;

  jtag_debug_scan_master dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ir(cmd_ir), .cmd_ir_only(cmd_ir_only), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .busy(busy),
    .tck(tck), .tdi(tdi), .tdo(tdo), .ir_in(ir_in), .vs_uir(vs_uir), .vs_cdr(vs_cdr),
    .vs_sdr(vs_sdr), .vs_udr(vs_udr), .jtag_state_rti(jtag_state_rti)
  );

  jtag_debug_scan_master #(.DR_WIDTH(S_DR), .IR_WIDTH(IR_W), .TCK_HALF(1)) dut_s (
    .clk(clk), .reset_n(reset_n), .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready),
    .cmd_ir(s_cmd_ir), .cmd_ir_only(s_cmd_ir_only), .cmd_data(s_cmd_data),
    .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_data(s_rsp_data), .busy(s_busy),
    .tck(s_tck), .tdi(s_tdi), .tdo(s_tdi), .ir_in(s_ir_in), .vs_uir(s_vs_uir), .vs_cdr(s_vs_cdr),
    .vs_sdr(s_vs_sdr), .vs_udr(s_vs_udr), .jtag_state_rti(s_rti)
  );

  int checks   = 0;
  int failures = 0;
  logic [DR_W-1:0] exp_q[$];
  logic [S_DR-1:0] exp_s_q[$];

  // Drive a command and return on the clk after the accept edge (cycle index 1).
  task automatic send_cmd(input logic [IR_W-1:0] ir, input logic ir_only,
                          input logic [DR_W-1:0] data, input logic [DR_W-1:0] exp);
    bit ok;
    bit rdy;
    ok = 0;
    cmd_ir = ir; cmd_ir_only = ir_only; cmd_data = data; cmd_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      rdy = cmd_ready;
      @(posedge clk);
      if (rdy) begin ok = 1; break; end
      #1;
    end
    #1;
    cmd_valid = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL accept: cmd_ready never seen, got 0 required 1");
    end else exp_q.push_back(exp);
  endtask

  // Follow a scan from cycle index 1 to its response, then complete the handshake.
  task automatic wait_scan(input string name, input logic [IR_W-1:0] exp_ir, input int exp_lat,
                           output int sdr_periods, output bit tdi_seen, output bit dr_seen);
    int cyc, lat, onehot_err, ir_err;
    bit tck_prev;
    logic [DR_W-1:0] exp_data;
    cyc = 1; lat = -1; onehot_err = 0; ir_err = 0; tck_prev = 0;
    sdr_periods = 0; tdi_seen = 0; dr_seen = 0;
    while (lat < 0 && cyc < 1000) begin
      if (rsp_valid) lat = cyc;
      else begin
        if (busy && $countones({vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti}) != 1) onehot_err++;
        if (ir_in !== exp_ir) ir_err++;
        if (vs_sdr && tck && !tck_prev) sdr_periods++;
        tck_prev = tck;
        if (tdi) tdi_seen = 1;
        if (vs_cdr || vs_sdr || vs_udr) dr_seen = 1;
        @(posedge clk); #1; cyc++;
      end
    end
    checks++;
    if (lat != exp_lat) begin
      failures++; $display("FAIL %s_latency: got %0d required %0d", name, lat, exp_lat);
    end
    checks++;
    if (onehot_err != 0) begin
      failures++; $display("FAIL %s_strobe_onehot: got %0d bad clks required 0", name, onehot_err);
    end
    checks++;
    if (ir_err != 0) begin
      failures++; $display("FAIL %s_ir_in: got %0d bad clks required 0 (ir %0d)", name, ir_err, exp_ir);
    end
    if (lat >= 0) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++; $display("FAIL %s_scoreboard: got unexpected response required none", name);
      end else begin
        exp_data = exp_q.pop_front();
        if (rsp_data !== exp_data) begin
          failures++; $display("FAIL %s_rsp_data: got %h required %h", name, rsp_data, exp_data);
        end
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
        failures++;
        $display("FAIL %s_handshake: got rsp_valid=%b cmd_ready=%b required 0 1", name, rsp_valid, cmd_ready);
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({tck, tdi, ir_in, vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti, rsp_valid, rsp_data, busy, cmd_ready} !== '0) begin
      failures++; $display("FAIL reset_outputs: got nonzero outputs required all 0");
    end
    checks++;
    if ({s_tck, s_tdi, s_ir_in, s_vs_uir, s_rti, s_rsp_valid, s_rsp_data, s_busy, s_cmd_ready} !== '0) begin
      failures++; $display("FAIL reset_outputs_small: got nonzero outputs required all 0");
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({cmd_ready, jtag_state_rti, busy, tck} !== 4'b1100) begin
      failures++;
      $display("FAIL reset_idle: got ready/rti/busy/tck=%b%b%b%b required 1100", cmd_ready, jtag_state_rti, busy, tck);
    end
  endtask

  task automatic test_loopback();
    int sdr; bit tdi_seen, dr_seen;
    logic [DR_W-1:0] d;
    d = 38'h0123456789;
    tdo_loop = 1'b1;
    send_cmd(2'b01, 1'b0, d, d);
    wait_scan("loopback", 2'b01, LAT_DR, sdr, tdi_seen, dr_seen);
    checks++;
    if (sdr != DR_W) begin
      failures++; $display("FAIL loopback_sdr_periods: got %0d required %0d", sdr, DR_W);
    end
  endtask

  task automatic test_tdo_high();
    int sdr; bit tdi_seen, dr_seen;
    tdo_loop = 1'b0; tdo_fixed = 1'b1;
    send_cmd(2'b01, 1'b0, '0, {DR_W{1'b1}});
    wait_scan("tdo_high", 2'b01, LAT_DR, sdr, tdi_seen, dr_seen);
    checks++;
    if (tdi_seen) begin
      failures++; $display("FAIL tdo_high_tdi: got tdi=1 at some clk required 0 throughout");
    end
    tdo_loop = 1'b1; tdo_fixed = 1'b0;
  endtask

  task automatic test_ir_only();
    int sdr; bit tdi_seen, dr_seen;
    send_cmd(2'b10, 1'b1, 38'h2A_5555_AAAA, '0);
    wait_scan("ir_only", 2'b10, LAT_IR, sdr, tdi_seen, dr_seen);
    checks++;
    if (dr_seen) begin
      failures++; $display("FAIL ir_only_dr_strobes: got a DR strobe high required none");
    end
  endtask

  task automatic test_back_to_back();
    int cyc, early, unstable, sdr; bit tdi_seen, dr_seen;
    logic [DR_W-1:0] a, b, snap, exp_data;
    a = 38'h15_0F0F_F0F0; b = 38'h2A_1234_5678;
    rsp_ready = 1'b0;
    send_cmd(2'b01, 1'b0, a, a);
    cmd_ir = 2'b11; cmd_ir_only = 1'b0; cmd_data = b; cmd_valid = 1'b1;
    cyc = 1; early = 0; unstable = 0;
    while (!rsp_valid && cyc < 1000) begin
      if (cmd_ready) early++;
      @(posedge clk); #1; cyc++;
    end
    checks++;
    if (cyc != LAT_DR) begin
      failures++; $display("FAIL b2b_first_latency: got %0d required %0d", cyc, LAT_DR);
    end
    snap = rsp_data;
    checks++;
    if (exp_q.size() == 0) begin
      failures++; $display("FAIL b2b_scoreboard: got empty queue required one entry");
    end else begin
      exp_data = exp_q.pop_front();
      if (rsp_data !== exp_data) begin
        failures++; $display("FAIL b2b_first_data: got %h required %h", rsp_data, exp_data);
      end
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (!rsp_valid || rsp_data !== snap || cmd_ready) unstable++;
    end
    checks++;
    if (unstable != 0 || early != 0) begin
      failures++; $display("FAIL b2b_hold: got %0d unstable, %0d ready clks required 0 0", unstable, early);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_return_idle: got valid/ready/busy=%b%b%b required 010", rsp_valid, cmd_ready, busy);
    end
    @(posedge clk);
    exp_q.push_back(b);
    #1;
    cmd_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || vs_uir !== 1'b1 || cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second_accept: got busy/uir/ready=%b%b%b required 110", busy, vs_uir, cmd_ready);
    end
    wait_scan("b2b_second", 2'b11, LAT_DR, sdr, tdi_seen, dr_seen);
  endtask

  task automatic test_reset_mid_scan();
    int cyc, stray, sdr; bit tdi_seen, dr_seen;
    logic [DR_W-1:0] d;
    d = 38'h33_CAFE_F00D;
    send_cmd(2'b01, 1'b0, d, d);
    cyc = 1;
    // SDR bit 10 spans cycle indices 49..52.
    while (cyc < 50) begin @(posedge clk); #1; cyc++; end
    checks++;
    if (vs_sdr !== 1'b1) begin
      failures++; $display("FAIL mid_reset_in_sdr: got vs_sdr=%b required 1", vs_sdr);
    end
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    exp_q.delete();
    checks++;
    if ({tck, tdi, ir_in, vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti, rsp_valid, rsp_data, busy, cmd_ready} !== '0) begin
      failures++; $display("FAIL mid_reset_outputs: got nonzero outputs required all 0");
    end
    stray = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (rsp_valid || busy) stray++;
    end
    checks++;
    if (stray != 0) begin
      failures++; $display("FAIL mid_reset_no_rsp: got %0d active clks required 0", stray);
    end
    send_cmd(2'b01, 1'b0, 38'h01_8421_0842, 38'h01_8421_0842);
    wait_scan("after_reset", 2'b01, LAT_DR, sdr, tdi_seen, dr_seen);
  endtask

  task automatic test_small();
    int cyc, lat, rise1, rise2;
    bit ok, rdy, prev;
    logic [S_DR-1:0] exp_data;
    s_cmd_ir = 2'b01; s_cmd_ir_only = 1'b0; s_cmd_data = 4'hA; s_rsp_ready = 1'b1; s_cmd_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      rdy = s_cmd_ready;
      @(posedge clk);
      if (rdy) begin ok = 1; break; end
      #1;
    end
    if (ok) exp_s_q.push_back(4'hA);
    #1;
    s_cmd_valid = 1'b0;
    cyc = 1; lat = -1; rise1 = -1; rise2 = -1; prev = 0;
    while (ok && lat < 0 && cyc < 200) begin
      if (s_rsp_valid) lat = cyc;
      else begin
        if (s_tck && !prev) begin
          if (rise1 < 0) rise1 = cyc;
          else if (rise2 < 0) rise2 = cyc;
        end
        prev = s_tck;
        @(posedge clk); #1; cyc++;
      end
    end
    checks++;
    if (lat != S_LAT) begin
      failures++; $display("FAIL small_latency: got %0d required %0d", lat, S_LAT);
    end
    checks++;
    if (rise2 - rise1 != 2) begin
      failures++; $display("FAIL small_tck_period: got %0d required 2", rise2 - rise1);
    end
    checks++;
    if (exp_s_q.size() == 0) begin
      failures++; $display("FAIL small_scoreboard: got empty queue required one entry");
    end else begin
      exp_data = exp_s_q.pop_front();
      if (s_rsp_data !== exp_data) begin
        failures++; $display("FAIL small_rsp_data: got %h required %h", s_rsp_data, exp_data);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_ir = '0; cmd_ir_only = 1'b0; cmd_data = '0;
    rsp_ready = 1'b1; tdo_loop = 1'b1; tdo_fixed = 1'b0;
    s_cmd_valid = 1'b0; s_cmd_ir = '0; s_cmd_ir_only = 1'b0; s_cmd_data = '0; s_rsp_ready = 1'b1;
    #1;
    test_reset();
    test_loopback();
    test_tdo_high();
    test_ir_only();
    test_back_to_back();
    test_reset_mid_scan();
    test_small();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jtag_debug_scan_master.md
Name: jtag_debug_scan_master

Overview:
- Single-clock scan initiator that drives the virtual-JTAG strobe interface a Nios debug-module TCK/sysclk pair consumes.
- Issues one IR update, then optionally one DR scan, per command. Shifts data in and out LSB first and returns the captured DR bits.
- Used as the simulation/host-side driver that exercises the debug module in place of the SLD hub.

Parameters:
DR_WIDTH, 38, DR scan length in bits (>=2)
IR_WIDTH, 2, instruction width
TCK_HALF, 2, sysclk cycles per tck half-period (>=1)

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready
cmd_ir  in  IR_WIDTH  instruction for the scan
cmd_ir_only  in  1  1 = IR update only, no DR scan
cmd_data  in  DR_WIDTH  DR bits to shift out
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed when rsp_valid&&rsp_ready
rsp_data  out  DR_WIDTH  captured DR bits (0 for IR-only)
busy  out  1  scan in progress (state not IDLE)
tck  out  1  generated scan clock
tdi  out  1  serial data to target
tdo  in  1  serial data from target
ir_in  out  IR_WIDTH  current instruction
vs_uir  out  1  update-IR strobe
vs_cdr  out  1  capture-DR strobe
vs_sdr  out  1  shift-DR strobe
vs_udr  out  1  update-DR strobe
jtag_state_rti  out  1  run-test-idle indicator

Behaviour:
- Interface: one clock (clk); reset_n is synchronous and active-low.
- Reset (reset_n=0 sampled at a clk edge) takes effect on the next cycle. All of the following are then 0: tck, tdi, ir_in, vs_*, jtag_state_rti, rsp_valid, rsp_data, busy, cmd_ready. State goes to IDLE.
- Reset mid-operation aborts the scan immediately. No response is produced.
- States: IDLE, UIR, CDR, SDR, UDR, RTI, RESP. All outputs are registered.
- IDLE behaviour:
  - cmd_ready=1, tck=0, jtag_state_rti=1.
  - On accept, latch cmd_ir, cmd_data and cmd_ir_only, clear the capture register, and enter UIR on the next clk.
- Period timing:
  - Every state except IDLE and RESP lasts exactly one tck period = 2*TCK_HALF clks.
  - tck=0 for the first TCK_HALF clks and 1 for the remaining TCK_HALF.
  - The state advances on the last clk of the period. A divider counter resets on each state entry.
- Strobe rule: exactly one of vs_uir/vs_cdr/vs_sdr/vs_udr/jtag_state_rti is high, for the whole period of UIR/CDR/SDR/UDR/RTI respectively.
- UIR:
  - ir_in takes the latched IR on entry and holds until the next command's UIR.
  - Next state is RTI if ir_only, else CDR.
- CDR: one period, then SDR.
- SDR:
  - Lasts DR_WIDTH periods, tracked by a bit counter 0..DR_WIDTH-1.
  - tdi = shift_reg[0] for the whole period.
  - On the clk where tck rises (first clk of the high half): capture = {tdo, capture[DR_WIDTH-1:1]} and shift_reg >>= 1.
  - After bit DR_WIDTH-1, go to UDR. tdi returns to 0 outside SDR.
- UDR → RTI → RESP.
- RESP:
  - rsp_valid=1 and rsp_data=capture (0 when ir_only), both held stable until rsp_ready.
  - On the handshake clk, go to IDLE; rsp_valid=0 on the next clk.
  - cmd_ready=0 in all non-IDLE states; commands are never queued.
- Latency: rsp_valid first asserts (K*2*TCK_HALF)+1 clks after the accept clk.
  - K = DR_WIDTH+4 for a DR scan; K = 2 for IR-only.
  - Defaults: 169 clks (DR), 9 clks (IR-only).
- cmd_valid is ignored outside IDLE. tdo is ignored outside SDR.

Test Plan:
- Loopback (tdo=tdi), cmd_ir=2'b01, cmd_data=38'h0123456789 → rsp_valid 169 clks after accept; rsp_data=38'h0123456789; 38 vs_sdr periods; ir_in=1.
- tdo tied 1, cmd_data=0 → rsp_data=38'h3F_FFFF_FFFF; tdi=0 throughout.
- IR-only with cmd_ir=2'b10 → ir_in=2 from UIR onward; vs_cdr/vs_sdr/vs_udr never high; rsp_valid 9 clks after accept; rsp_data=0.
- Hold rsp_ready=0 for 20 clks with a second cmd_valid pending → rsp_valid and rsp_data stable, cmd_ready=0; second command accepted on the first clk after the rsp handshake returns to IDLE.
- reset_n=0 for one clk at SDR bit 10 → next clk: all outputs 0, no rsp_valid; a fresh loopback command then completes correctly.
- TCK_HALF=1, DR_WIDTH=4, loopback 4'hA → tck period 2 clks; rsp_valid 17 clks after accept; rsp_data=4'hA.
